// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencing / hazard controller.
// PIPE_HAZARD_FWD_EN selects operand forwarding (FWD_EN=1) versus stall-until-writeback.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        INIT,
        WARM,
        RUN
    } ctrl_state_t;

    localparam int FWD_RF    = 0;
    // Tag destination field is sized for the widest register index we support.
    localparam int DST_MAX_W = 8;

`ifdef PIPE_HAZARD_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    typedef struct packed {
        logic                 valid;
        logic                 we;
        logic                 load;
        logic [DST_MAX_W-1:0] dst;
    } stage_tag_t;

endpackage

// File: rtl/hazard_match.sv
// Priority match of one source register against all in-flight stage tags.
// Readiness limits depend on PIPE_HAZARD_FWD_EN (via pipe_ctrl_pkg::FWD_EN).
module hazard_match
    import pipe_ctrl_pkg::*;
#(
    parameter int STAGES         = 5,
    parameter int ALU_RDY_STAGE  = 1,
    parameter int LOAD_RDY_STAGE = 3,
    parameter int SW             = $clog2(STAGES + 1)
) (
    input  logic                    use_src,
    input  logic [DST_MAX_W-1:0]    src,
    input  stage_tag_t [STAGES-1:0] tags,
    output logic                    hit,
    output logic [SW-1:0]           stage_idx,
    output logic                    needs_stall
);
    // Without forwarding no in-flight producer is ever ready.
    localparam int ALU_LIM  = FWD_EN ? ALU_RDY_STAGE  : STAGES;
    localparam int LOAD_LIM = FWD_EN ? LOAD_RDY_STAGE : STAGES;

    int   hit_k;
    logic hit_load;

    always_comb begin
        hit      = 1'b0;
        hit_k    = 0;
        hit_load = 1'b0;
        // Oldest to youngest, so the youngest match overwrites the rest.
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (use_src && tags[k].valid && tags[k].we && (tags[k].dst == src)) begin
                hit      = 1'b1;
                hit_k    = k;
                hit_load = tags[k].load;
            end
        end
        stage_idx   = SW'(hit_k);
        needs_stall = hit && (hit_k < (hit_load ? LOAD_LIM : ALU_LIM));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing, hazard stall, forwarding select and branch flush control.
// Forwarding is enabled by defining PIPE_HAZARD_FWD_EN.
//
//   state | meaning
//   INIT  | load reset vector into PC, hold issue
//   WARM  | fetch path filling for FETCH_LAT cycles, no issue
//   RUN   | normal issue with hazard / branch handling
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STAGES         = 5,
    parameter int REG_W          = 4,
    parameter int BR_STAGE       = 1,
    parameter int ALU_RDY_STAGE  = 1,
    parameter int LOAD_RDY_STAGE = 3,
    parameter int FETCH_LAT      = 2,
    localparam int SW            = $clog2(STAGES + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 instr_valid,
    input  logic [3*REG_W-1:0]   src_idx,
    input  logic [2:0]           src_use,
    input  logic [REG_W-1:0]     dst_idx,
    input  logic                 dst_we,
    input  logic                 is_load,
    input  logic                 br_taken,
    output logic                 sel_pc_init,
    output logic                 stall,
    output logic                 issue,
    output logic [STAGES-1:0]    stage_valid,
    output logic [STAGES-1:0]    flush,
    output logic [3*SW-1:0]      fwd_sel
);
    localparam int SQ_W = $clog2(FETCH_LAT + 1);
    localparam logic [STAGES-1:0] FLUSH_MASK = STAGES'((1 << BR_STAGE) - 1);

    ctrl_state_t             state, state_nxt;
    stage_tag_t [STAGES-1:0] tags;
    stage_tag_t              new_tag;
    logic [SQ_W-1:0]         sq_cnt, sq_cnt_nxt;
    logic                    squashing, br_kill;
    logic [2:0]              hit, needs_stall;
    logic [SW-1:0]           hit_stage [3];

    assign br_kill   = br_taken & tags[BR_STAGE].valid;
    assign squashing = (sq_cnt != '0);
    assign flush     = br_kill ? FLUSH_MASK : '0;
    assign new_tag   = '{valid: 1'b1, we: dst_we, load: is_load, dst: DST_MAX_W'(dst_idx)};

    for (genvar s = 0; s < 3; s++) begin : g_src
        hazard_match #(
            .STAGES         (STAGES),
            .ALU_RDY_STAGE  (ALU_RDY_STAGE),
            .LOAD_RDY_STAGE (LOAD_RDY_STAGE),
            .SW             (SW)
        ) u_match (
            .use_src     (src_use[s]),
            .src         (DST_MAX_W'(src_idx[s*REG_W +: REG_W])),
            .tags        (tags),
            .hit         (hit[s]),
            .stage_idx   (hit_stage[s]),
            .needs_stall (needs_stall[s])
        );
    end

    always_comb begin
        stage_valid = '0;
        for (int k = 0; k < STAGES; k++) stage_valid[k] = tags[k].valid;
    end

    always_comb begin
        state_nxt   = state;
        sel_pc_init = 1'b0;
        stall       = 1'b0;
        issue       = 1'b0;
        sq_cnt_nxt  = squashing ? sq_cnt - SQ_W'(1) : sq_cnt;
        case (state)
            INIT: begin
                sel_pc_init = 1'b1;
                stall       = 1'b1;
                sq_cnt_nxt  = SQ_W'(FETCH_LAT);
                state_nxt   = WARM;
            end
            // Warm-up reuses the squash down-counter loaded in INIT.
            WARM: if (sq_cnt == SQ_W'(1)) state_nxt = RUN;
            RUN: begin
                stall = instr_valid & ~squashing & ~br_kill & (|needs_stall);
                issue = instr_valid & ~squashing & ~br_kill & ~stall;
            end
            default: state_nxt = INIT;
        endcase
        if (br_kill) sq_cnt_nxt = SQ_W'(FETCH_LAT);
    end

    always_comb begin
        fwd_sel = '0;
        for (int s = 0; s < 3; s++) begin
            if (FWD_EN && (state == RUN) && !stall && !squashing && hit[s] && !needs_stall[s])
                fwd_sel[s*SW +: SW] = hit_stage[s] + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= INIT;
            sq_cnt <= '0;
            tags   <= '0;
        end else begin
            state   <= state_nxt;
            sq_cnt  <= sq_cnt_nxt;
            tags[0] <= issue ? new_tag : '0;
            // Younger stages hit by a branch become bubbles instead of advancing.
            for (int k = 1; k < STAGES; k++)
                tags[k] <= flush[k-1] ? '0 : tags[k-1];
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed table-driven bench for pipe_hazard_ctrl with default parameters.
// Expectations follow PIPE_HAZARD_FWD_EN when the macro is defined for the build.
module tb_pipe_hazard_ctrl;
`ifdef PIPE_HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid, dst_we, is_load, br_taken;
    logic [11:0] src_idx;
    logic [2:0]  src_use;
    logic [3:0]  dst_idx;
    logic        sel_pc_init, stall, issue;
    logic [4:0]  stage_valid, flush;
    logic [8:0]  fwd_sel;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic       sel;
        logic       stall;
        logic       issue;
        logic [4:0] valid;
        logic [4:0] flush;
        logic [8:0] fwd;
    } obs_t;

    typedef struct {
        logic iv;
        logic br;
        obs_t x;
    } vec_t;

    vec_t vecs [22];
    obs_t m_all, m_nov;

    pipe_hazard_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .src_idx     (src_idx),
        .src_use     (src_use),
        .dst_idx     (dst_idx),
        .dst_we      (dst_we),
        .is_load     (is_load),
        .br_taken    (br_taken),
        .sel_pc_init (sel_pc_init),
        .stall       (stall),
        .issue       (issue),
        .stage_valid (stage_valid),
        .flush       (flush),
        .fwd_sel     (fwd_sel)
    );

    always #5 clk = ~clk;

    function automatic obs_t o(input logic s, input logic st, input logic is,
                               input logic [4:0] v, input logic [4:0] f, input logic [8:0] fw);
        return {s, st, is, v, f, fw};
    endfunction

    function automatic vec_t mkv(input logic iv, input logic br, input obs_t x);
        vec_t v;
        v.iv = iv;
        v.br = br;
        v.x  = x;
        return v;
    endfunction

    function automatic string fmt(input obs_t a);
        return $sformatf("sel=%b stall=%b issue=%b valid=%b flush=%b fwd=%h",
                         a.sel, a.stall, a.issue, a.valid, a.flush, a.fwd);
    endfunction

    task automatic drive(input logic iv, input logic [11:0] s, input logic [2:0] u,
                         input logic [3:0] d, input logic we, input logic ld, input logic br);
        instr_valid = iv;
        src_idx     = s;
        src_use     = u;
        dst_idx     = d;
        dst_we      = we;
        is_load     = ld;
        br_taken    = br;
        #4;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input obs_t exp, input obs_t msk);
        obs_t act;
        act = {sel_pc_init, stall, issue, stage_valid, flush, fwd_sel};
        n_tests++;
        if ((act & msk) !== (exp & msk)) begin
            n_fail++;
            $display("FAIL %s: got %s, want %s", nm, fmt(act), fmt(exp));
        end
    endtask

    // Consumer that stalls n_stall cycles, then issues with the given forward select.
    task automatic use_seq(input string nm, input logic [11:0] s, input logic [2:0] u,
                           input int n_stall, input logic [8:0] xfwd);
        for (int i = 0; i < n_stall; i++) begin
            drive(1'b1, s, u, 4'd15, 1'b0, 1'b0, 1'b0);
            chk($sformatf("%s_stall%0d", nm, i), o(1'b0, 1'b1, 1'b0, 5'b0, 5'b0, 9'h0), m_nov);
            tick();
        end
        drive(1'b1, s, u, 4'd15, 1'b0, 1'b0, 1'b0);
        chk($sformatf("%s_issue", nm), o(1'b0, 1'b0, 1'b1, 5'b0, 5'b0, xfwd), m_nov);
        tick();
    endtask

    initial begin
        m_all = '1;
        m_nov = o(1'b1, 1'b1, 1'b1, 5'b0, 5'h1f, 9'h1ff);

        // Start-up, drain, branch with/without a younger victim, ignored branch.
        vecs[0]  = mkv(1, 0, o(1, 1, 0, 5'b00000, 5'b00000, 9'h0));
        vecs[1]  = mkv(1, 0, o(0, 0, 0, 5'b00000, 5'b00000, 9'h0));
        vecs[2]  = mkv(1, 0, o(0, 0, 0, 5'b00000, 5'b00000, 9'h0));
        vecs[3]  = mkv(1, 0, o(0, 0, 1, 5'b00000, 5'b00000, 9'h0));
        vecs[4]  = mkv(1, 0, o(0, 0, 1, 5'b00001, 5'b00000, 9'h0));
        vecs[5]  = mkv(0, 0, o(0, 0, 0, 5'b00011, 5'b00000, 9'h0));
        vecs[6]  = mkv(0, 0, o(0, 0, 0, 5'b00110, 5'b00000, 9'h0));
        vecs[7]  = mkv(0, 0, o(0, 0, 0, 5'b01100, 5'b00000, 9'h0));
        vecs[8]  = mkv(0, 0, o(0, 0, 0, 5'b11000, 5'b00000, 9'h0));
        vecs[9]  = mkv(0, 0, o(0, 0, 0, 5'b10000, 5'b00000, 9'h0));
        vecs[10] = mkv(1, 0, o(0, 0, 1, 5'b00000, 5'b00000, 9'h0));
        vecs[11] = mkv(0, 0, o(0, 0, 0, 5'b00001, 5'b00000, 9'h0));
        vecs[12] = mkv(1, 1, o(0, 0, 0, 5'b00010, 5'b00001, 9'h0));
        vecs[13] = mkv(1, 0, o(0, 0, 0, 5'b00100, 5'b00000, 9'h0));
        vecs[14] = mkv(1, 0, o(0, 0, 0, 5'b01000, 5'b00000, 9'h0));
        vecs[15] = mkv(1, 0, o(0, 0, 1, 5'b10000, 5'b00000, 9'h0));
        vecs[16] = mkv(1, 0, o(0, 0, 1, 5'b00001, 5'b00000, 9'h0));
        vecs[17] = mkv(1, 1, o(0, 0, 0, 5'b00011, 5'b00001, 9'h0));
        vecs[18] = mkv(0, 0, o(0, 0, 0, 5'b00100, 5'b00000, 9'h0));
        vecs[19] = mkv(0, 0, o(0, 0, 0, 5'b01000, 5'b00000, 9'h0));
        vecs[20] = mkv(0, 0, o(0, 0, 0, 5'b10000, 5'b00000, 9'h0));
        vecs[21] = mkv(1, 1, o(0, 0, 1, 5'b00000, 5'b00000, 9'h0));

        drive(1'b0, 12'h0, 3'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        drive(1'b1, 12'h0, 3'b0, 4'd1, 1'b1, 1'b0, 1'b0);
        chk("in_reset", o(1, 1, 0, 5'b0, 5'b0, 9'h0), m_all);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int r = 0; r < 22; r++) begin
            drive(vecs[r].iv, 12'h0, 3'b0, 4'd1, 1'b1, 1'b0, vecs[r].br);
            chk($sformatf("row%0d", r), vecs[r].x, m_all);
            tick();
        end

        // ALU producer followed immediately by a consumer on rn.
        drive(1'b1, 12'h000, 3'b000, 4'd3, 1'b1, 1'b0, 1'b0);
        chk("add_r3", o(0, 0, 1, 5'b0, 5'b0, 9'h0), m_nov);
        tick();
        use_seq("sub_r3", 12'h003, 3'b001, FWD ? 1 : 5, FWD ? 9'h002 : 9'h000);

        // Load-use on rm.
        drive(1'b1, 12'h000, 3'b000, 4'd2, 1'b1, 1'b1, 1'b0);
        chk("ldr_r2", o(0, 0, 1, 5'b0, 5'b0, 9'h0), m_nov);
        tick();
        use_seq("use_r2", 12'h020, 3'b010, FWD ? 3 : 5, FWD ? 9'h020 : 9'h000);

        // Older load and younger ALU write r8; only the ALU one may decide (rs).
        drive(1'b1, 12'h000, 3'b000, 4'd8, 1'b1, 1'b1, 1'b0);
        chk("ldr_r8", o(0, 0, 1, 5'b0, 5'b0, 9'h0), m_nov);
        tick();
        drive(1'b1, 12'h000, 3'b000, 4'd8, 1'b1, 1'b0, 1'b0);
        chk("add_r8", o(0, 0, 1, 5'b0, 5'b0, 9'h0), m_nov);
        tick();
        use_seq("use_r8", 12'h800, 3'b100, FWD ? 1 : 5, FWD ? 9'h080 : 9'h000);

        // Branch resolving during a load-use stall.
        drive(1'b1, 12'h000, 3'b000, 4'd9, 1'b1, 1'b1, 1'b0);
        chk("ldr_r9", o(0, 0, 1, 5'b0, 5'b0, 9'h0), m_nov);
        tick();
        drive(1'b1, 12'h009, 3'b001, 4'd15, 1'b0, 1'b0, 1'b0);
        chk("use_r9_stall", o(0, 1, 0, 5'b0, 5'b0, 9'h0), m_nov);
        tick();
        drive(1'b1, 12'h009, 3'b001, 4'd15, 1'b0, 1'b0, 1'b1);
        chk("br_in_stall", o(0, 0, 0, 5'b0, 5'b00001, 9'h0), m_nov);
        tick();
        drive(1'b1, 12'h009, 3'b001, 4'd15, 1'b0, 1'b0, 1'b0);
        chk("squash1", o(0, 0, 0, 5'b0, 5'b0, 9'h0), m_nov);
        tick();
        drive(1'b1, 12'h009, 3'b001, 4'd15, 1'b0, 1'b0, 1'b0);
        chk("squash2", o(0, 0, 0, 5'b0, 5'b0, 9'h0), m_nov);
        tick();
        drive(1'b1, 12'h000, 3'b000, 4'd1, 1'b1, 1'b0, 1'b0);
        chk("post_squash", o(0, 0, 1, 5'b0, 5'b0, 9'h0), m_nov);
        tick();

        // Fill the pipe, then reset mid-cycle.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 12'h000, 3'b000, 4'd1, 1'b1, 1'b0, 1'b0);
            chk($sformatf("fill%0d", i), o(0, 0, 1, 5'b0, 5'b0, 9'h0), m_nov);
            tick();
        end
        drive(1'b1, 12'h000, 3'b000, 4'd1, 1'b1, 1'b0, 1'b0);
        chk("full_pipe", o(0, 0, 1, 5'b11111, 5'b0, 9'h0), m_all);
        rst_n = 1'b0;
        #1;
        chk("async_reset", o(1, 1, 0, 5'b0, 5'b0, 9'h0), m_all);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 12'h000, 3'b000, 4'd1, 1'b1, 1'b0, 1'b0);
        chk("re_init", o(1, 1, 0, 5'b0, 5'b0, 9'h0), m_all);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 12'h000, 3'b000, 4'd1, 1'b1, 1'b0, 1'b0);
            chk($sformatf("re_warm%0d", i), o(0, 0, 0, 5'b0, 5'b0, 9'h0), m_all);
            tick();
        end
        drive(1'b1, 12'h000, 3'b000, 4'd1, 1'b1, 1'b0, 1'b0);
        chk("re_run", o(0, 0, 1, 5'b0, 5'b0, 9'h0), m_all);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
